// File: rtl/life_pkg.sv
// Shared Life types: grid geometry, grid/row vectors, scanner FSM states.
// Imported by the grid engine and the LED matrix scanner.
package life_pkg;

  localparam int GRID_SIZE = 8;

  typedef logic [GRID_SIZE*GRID_SIZE-1:0] grid_t;
  typedef logic [GRID_SIZE-1:0]           row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } scan_state_t;

endpackage

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 LED driver, double-buffered generation input.
// Ports: clk, rst, ena, grid_in/grid_valid/grid_ready, rows_out, columns_out, frame_done.
module led_matrix_scanner
  import life_pkg::*;
#(
  parameter int CYCLES_PER_ROW = 1,
  parameter int BLANK_CYCLES   = 0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  ena,
  input  grid_t grid_in,
  input  logic  grid_valid,
  output logic  grid_ready,
  output row_t  rows_out,
  output row_t  columns_out,
  output logic  frame_done
);

  localparam int TW =
    (CYCLES_PER_ROW > 1) ? $clog2(CYCLES_PER_ROW) : 1;
  localparam logic [TW-1:0] LAST_TICK =
    TW'(CYCLES_PER_ROW - 1);

  scan_state_t   state;
  logic [2:0]    row_idx;
  logic [TW-1:0] tick;
  grid_t         active;
  grid_t         pending;
  logic          pending_full;

  logic          last_tick;
  logic          frame_end;
  logic          swap;
  logic          take;
  logic [2:0]    nxt_row;
  logic [TW-1:0] nxt_tick;
  scan_state_t   nxt_state;
  grid_t         nxt_active;
  logic          lit;

  assign grid_ready = ~pending_full;
  assign last_tick  = (tick == LAST_TICK);
  assign frame_end  = (state == S_DRIVE) && last_tick
                    && (row_idx == 3'd7);
  assign swap       = ena && frame_end && pending_full;
  assign take       = grid_valid && !pending_full;
  assign nxt_active = swap ? pending : active;

  // Position the outputs will show after this edge.
  always_comb begin
    nxt_row  = row_idx;
    nxt_tick = tick;
    if (state == S_IDLE) begin
      nxt_row  = 3'd0;
      nxt_tick = '0;
    end else if (last_tick) begin
      nxt_row  = row_idx + 3'd1;
      nxt_tick = '0;
    end else begin
      nxt_tick = tick + TW'(1);
    end
    nxt_state = (int'(nxt_tick) < BLANK_CYCLES)
              ? S_BLANK : S_DRIVE;
    lit = (nxt_state == S_DRIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      row_idx      <= 3'd0;
      tick         <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      rows_out     <= '0;
      columns_out  <= '0;
      frame_done   <= 1'b0;
    end else begin
      if (swap) begin
        active       <= pending;
        pending_full <= 1'b0;
      end
      if (take) begin
        pending      <= grid_in;
        pending_full <= 1'b1;
      end
      if (ena) begin
        state      <= nxt_state;
        row_idx    <= nxt_row;
        tick       <= nxt_tick;
        rows_out   <= lit ? (row_t'(1) << nxt_row) : '0;
        columns_out <= lit
          ? nxt_active[{nxt_row, 3'b000} +: GRID_SIZE]
          : '0;
        frame_done <= (nxt_row == 3'd7)
                    && (nxt_tick == LAST_TICK);
      end else begin
        rows_out    <= '0;
        columns_out <= '0;
        frame_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench: two scanner configurations driven in parallel,
// compared against a slot-position reference model.
module tb_led_matrix_scanner;

  typedef struct packed {
    logic [7:0] rows;
    logic [7:0] cols;
    logic       fd;
    logic       rdy;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        ena = 0;
  logic [63:0] grid_in = '0;
  logic        grid_valid = 0;

  logic       rdy0, rdy1, fd0, fd1;
  logic [7:0] rows0, rows1, cols0, cols1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_matrix_scanner u0 (
    .clk(clk), .rst(rst), .ena(ena),
    .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ready(rdy0), .rows_out(rows0),
    .columns_out(cols0), .frame_done(fd0)
  );

  led_matrix_scanner #(
    .CYCLES_PER_ROW(4), .BLANK_CYCLES(1)
  ) u1 (
    .clk(clk), .rst(rst), .ena(ena),
    .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ready(rdy1), .rows_out(rows1),
    .columns_out(cols1), .frame_done(fd1)
  );

  // Reference model: the display position is just the count of
  // enabled edges since reset, folded into an 8-row frame.
  int          cpr [2] = '{1, 4};
  int          blk [2] = '{0, 1};
  bit          started [2];
  int          pos [2];
  logic [63:0] m_act [2];
  logic [63:0] m_pend [2];
  bit          m_full [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  function automatic void m_reset(int k);
    started[k] = 0;
    pos[k]     = 0;
    m_act[k]   = '0;
    m_pend[k]  = '0;
    m_full[k]  = 0;
  endfunction

  function automatic exp_t m_step(int k, bit v,
                                  logic [63:0] d, bit en);
    exp_t e;
    int   per;
    int   row;
    int   tk;
    bit   swap;
    per  = 8 * cpr[k];
    swap = en && started[k] && (pos[k] == per - 1)
        && m_full[k];
    if (swap) begin
      m_act[k]  = m_pend[k];
      m_full[k] = 0;
    end else if (v && !m_full[k]) begin
      m_pend[k] = d;
      m_full[k] = 1;
    end
    e = '0;
    if (en) begin
      if (!started[k]) begin
        started[k] = 1;
        pos[k]     = 0;
      end else begin
        pos[k] = (pos[k] + 1) % per;
      end
      row = pos[k] / cpr[k];
      tk  = pos[k] % cpr[k];
      if (tk >= blk[k]) begin
        e.rows = 8'(1 << row);
        e.cols = m_act[k][row*8 +: 8];
      end
      e.fd = (pos[k] == per - 1);
    end
    e.rdy = !m_full[k];
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_reset(0);
      m_reset(1);
      q0.delete();
      q1.delete();
    end else begin
      q0.push_back(m_step(0, grid_valid, grid_in, ena));
      q1.push_back(m_step(1, grid_valid, grid_in, ena));
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per edge per DUT.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0 {rows,cols,fd,rdy}",
          32'({rows0, cols0, fd0, rdy0}), 32'(e));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1 {rows,cols,fd,rdy}",
          32'({rows1, cols1, fd1, rdy1}), 32'(e));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold valid until DUT0 takes it, with a cycle budget.
  task automatic send(logic [63:0] d);
    bit done;
    done       = 0;
    grid_in    = d;
    grid_valid = 1;
    for (int i = 0; i < 200; i++) begin
      if (rdy0) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    grid_valid = 0;
    grid_in    = '0;
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL send: grid_ready stayed 0 past budget");
    end
  endtask

  task automatic chk_dark(string name);
    chk({name, " rows0"}, 32'(rows0), 32'h0);
    chk({name, " cols0"}, 32'(cols0), 32'h0);
    chk({name, " fd0"}, 32'(fd0), 32'h0);
    chk({name, " rdy0"}, 32'(rdy0), 32'h1);
    chk({name, " rows1"}, 32'(rows1), 32'h0);
    chk({name, " cols1"}, 32'(cols1), 32'h0);
    chk({name, " rdy1"}, 32'(rdy1), 32'h1);
  endtask

  logic [63:0] glider;
  bit          hit;

  initial begin
    glider = 64'h0000_0000_0007_0402;
    cyc(2);
    chk_dark("reset");
    rst = 0;
    ena = 1;
    cyc(2);
    send(glider);
    cyc(20);
    send(64'hA5A5_5A5A_0F0F_F0F0);
    send(64'h1122_3344_5566_7788);
    cyc(40);
    ena = 0;
    cyc(5);
    ena = 1;
    cyc(10);
    send(64'hDEAD_BEEF_CAFE_F00D);
    cyc(3);
    send(64'h0123_4567_89AB_CDEF);
    hit = 0;
    for (int i = 0; i < 64; i++) begin
      if (rows0 == 8'h20) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("row5 reached", 32'(hit), 32'h1);
    #2 rst = 1;
    #1 chk_dark("async reset");
    cyc(2);
    rst = 0;
    cyc(40);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        send({$urandom, $urandom});
      ena = ($urandom_range(0, 5) != 0);
      cyc($urandom_range(1, 12));
    end
    ena = 1;
    cyc(80);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
